// File: rtl/score_keeper.sv
// score_keeper
// Game-session front end for the score recorder. Runs the play/death state
// machine, counts the live score as two BCD digits and emits a one-cycle
// slime_die pulse when the death delay expires. The recorder latches
// score_0/score_1 on that pulse.
//
// Optional build macro: SCORE_KEEPER_PAUSE_EN adds the pause input.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      single-cycle request to begin a new game (IDLE/OVER only)
//   pass       single-cycle pulse, obstacle cleared, +1 point
//   collide    slime hit an obstacle (level or pulse)
//   pause      (SCORE_KEEPER_PAUSE_EN only) freeze PLAY/DYING while high
//   score_0    BCD ones digit, registered
//   score_1    BCD tens digit, registered
//   slime_die  one-cycle registered pulse on the first OVER cycle
//   playing    high in PLAY and DYING
//   game_over  high in OVER
module score_keeper #(
   parameter int unsigned DIE_DELAY = 4,   // 1..255
   parameter int unsigned MAX_TENS  = 9    // 0..9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pass,
   input  logic       collide,
`ifdef SCORE_KEEPER_PAUSE_EN
   input  logic       pause,
`endif
   output logic [3:0] score_0,
   output logic [3:0] score_1,
   output logic       slime_die,
   output logic       playing,
   output logic       game_over
);

   typedef enum logic [1:0] {IDLE, PLAY, DYING, OVER} state_t;

   localparam logic [7:0] CNT_LOAD = 8'(DIE_DELAY - 1);
   localparam logic [3:0] TENS_TOP = 4'(MAX_TENS);

   state_t     state;
   logic [7:0] cnt;
   logic       hold;

`ifdef SCORE_KEEPER_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   // playing/game_over are written alongside every state change so they
   // track the state register exactly without an extra cycle of lag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         score_0   <= 4'd0;
         score_1   <= 4'd0;
         slime_die <= 1'b0;
         playing   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         slime_die <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= PLAY;
                  score_0 <= 4'd0;
                  score_1 <= 4'd0;
                  playing <= 1'b1;
               end
            end
            PLAY: begin
               if (!hold) begin
                  if (collide) begin
                     // collide wins over a simultaneous pass
                     state <= DYING;
                     cnt   <= CNT_LOAD;
                  end else if (pass) begin
                     if (score_0 != 4'd9) begin
                        score_0 <= score_0 + 4'd1;
                     end else if (score_1 < TENS_TOP) begin
                        score_0 <= 4'd0;
                        score_1 <= score_1 + 4'd1;
                     end
                     // else saturated: hold at MAX_TENS*10+9
                  end
               end
            end
            DYING: begin
               if (!hold) begin
                  if (cnt == 8'd0) begin
                     state     <= OVER;
                     slime_die <= 1'b1;
                     playing   <= 1'b0;
                     game_over <= 1'b1;
                  end else begin
                     cnt <= cnt - 8'd1;
                  end
               end
            end
            OVER: begin
               // start in the slime_die cycle is fine: the recorder samples
               // the old score on this same edge.
               if (start) begin
                  state     <= PLAY;
                  score_0   <= 4'd0;
                  score_1   <= 4'd0;
                  playing   <= 1'b1;
                  game_over <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               playing   <= 1'b0;
               game_over <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;
   localparam int DIE_DELAY = 4;
   localparam int MAX_TENS  = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, pass = 1'b0, collide = 1'b0;
`ifdef SCORE_KEEPER_PAUSE_EN
   logic pause = 1'b0;
`endif
   logic [3:0] score_0, score_1;
   logic       slime_die, playing, game_over;

   always #5 clk = ~clk;

   score_keeper #(.DIE_DELAY(DIE_DELAY), .MAX_TENS(MAX_TENS)) dut (
      .clk(clk), .rst(rst), .start(start), .pass(pass), .collide(collide),
`ifdef SCORE_KEEPER_PAUSE_EN
      .pause(pause),
`endif
      .score_0(score_0), .score_1(score_1), .slime_die(slime_die),
      .playing(playing), .game_over(game_over)
   );

   int checks = 0;
   int failures = 0;

   // ---------------- behavioural model ----------------
   // Score kept as a plain integer; phase 0=idle 1=play 2=dying 3=over.
   int m_phase, m_score, m_left, m_rec;
   bit m_die;
   logic m_hold;
`ifdef SCORE_KEEPER_PAUSE_EN
   assign m_hold = pause;
`else
   assign m_hold = 1'b0;
`endif

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0; m_score <= 0; m_left <= 0; m_die <= 0;
      end else begin
         m_die <= 0;
         if (m_phase == 0 || m_phase == 3) begin
            if (start) begin m_phase <= 1; m_score <= 0; end
         end else if (!m_hold) begin
            if (m_phase == 1) begin
               if (collide) begin m_phase <= 2; m_left <= DIE_DELAY; end
               else if (pass && m_score < MAX_TENS*10+9) m_score <= m_score + 1;
            end else begin
               // m_left = DYING cycles still to spend
               if (m_left == 1) begin m_phase <= 3; m_die <= 1; m_rec <= m_score; end
               else m_left <= m_left - 1;
            end
         end
      end
   end

   // shadow recorder latching the DUT score on slime_die
   logic [7:0] rec_dut = 8'h00;
   always @(posedge clk) if (slime_die) rec_dut <= {score_1, score_0};

   // ---------------- per-cycle compare ----------------
   bit chk_en = 0;
   bit saw_die = 0;
   int cyc = 0;
   always @(negedge clk) begin
      cyc++;
      if (slime_die) saw_die = 1;
      if (chk_en) begin
         checks++;
         if (int'(score_0) != m_score % 10 || int'(score_1) != m_score / 10 ||
             slime_die !== m_die || playing !== (m_phase == 1 || m_phase == 2) ||
             game_over !== (m_phase == 3)) begin
            failures++;
            $display("FAIL model cyc=%0d got s=%0d%0d die=%b play=%b over=%b want s=%0d die=%b phase=%0d",
                     cyc, score_1, score_0, slime_die, playing, game_over, m_score, m_die, m_phase);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic p, input logic c);
      start = s; pass = p; collide = c;
      @(negedge clk);
      start = 0; pass = 0; collide = 0;
   endtask

   // cycles from the collide-sampling edge until slime_die is seen
   task automatic wait_die(output int n);
      n = 0;
      while (!slime_die && n < 40) begin step(0, 0, 0); n++; end
   endtask

   int n;

   initial begin
      #12;
      check("reset_score", {score_1, score_0}, 0);
      check("reset_flags", {slime_die, playing, game_over}, 0);
      @(negedge clk); rst = 0; chk_en = 1;

      // start then 12 passes -> 12
      step(1, 0, 0);
      repeat (12) step(0, 1, 0);
      check("bcd12", {score_1, score_0}, 8'h12);
      check("playing12", playing, 1);
      check("no_die12", saw_die, 0);

      // 105 passes total -> saturates at 99
      repeat (93) step(0, 1, 0);
      check("sat99", {score_1, score_0}, 8'h99);

      // die at 99, stay in OVER
      step(0, 0, 1);
      wait_die(n);
      check("die_latency_a", n, DIE_DELAY);
      repeat (3) step(0, 0, 0);
      check("over_hold", {game_over, slime_die, playing}, 3'b100);
      check("rec99", rec_dut, 8'h99);

      // new game, 07, pass+collide together, start in slime_die cycle
      step(1, 0, 0);
      repeat (7) step(0, 1, 0);
      step(0, 1, 1);
      check("collide_wins", {score_1, score_0}, 8'h07);
      wait_die(n);
      check("die_latency_b", n, DIE_DELAY);
      check("die_score07", {score_1, score_0}, 8'h07);
      step(1, 0, 0);
      check("restart_score", {score_1, score_0}, 0);
      check("restart_flags", {playing, game_over, slime_die}, 3'b100);
      check("rec07", rec_dut, 8'h07);

      // async reset two cycles into DYING
      repeat (3) step(0, 1, 0);
      step(0, 0, 1);
      step(0, 0, 0); step(0, 0, 0);
      #2 rst = 1;
      #1;
      check("async_rst", {score_1, score_0, slime_die, playing, game_over}, 0);
      saw_die = 0;
      @(negedge clk); rst = 0;
      repeat (10) step(0, 1, 1);
      check("no_die_after_rst", saw_die, 0);
      check("idle_after_rst", {score_1, score_0, playing, game_over}, 0);

`ifdef SCORE_KEEPER_PAUSE_EN
      step(1, 0, 0);
      repeat (3) step(0, 1, 0);
      pause = 1;
      for (int i = 0; i < 10; i++) step(0, (i % 3) == 0, 0);
      pause = 0;
      check("pause_hold", {score_1, score_0}, 8'h03);
      step(0, 0, 1);
      step(0, 0, 0);
      pause = 1; step(0, 0, 0); step(0, 0, 0); pause = 0;
      wait_die(n);
      check("pause_stretch", n + 3, DIE_DELAY + 2);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
`ifdef SCORE_KEEPER_PAUSE_EN
         pause = ($urandom_range(0, 7) == 0);
`endif
         step($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 24) == 0);
         if ($urandom_range(0, 799) == 0) begin
            #2 rst = 1;
            @(negedge clk); rst = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
